uart_link: RTL

Full-duplex 8N1 serial link between the simulated-device top level and the external car simulator. The transmit side streams the 8-bit command byte continuously: frame flag bits, beacon place/destroy requests, and the 4-bit moving state. The receive side decodes the simulator's reply frames into the detector byte, where bit 0 is front, bit 1 is left, bit 2 is right and bit 3 is back. It sits directly between the top-level control logic and the tx/rx pins.

---
 rtl/uart_link.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_link.sv
// uart_link: full-duplex 8N1 serial link. The transmit side streams the command
// byte back-to-back with a fixed idle gap between frames; the receive side
// decodes reply frames from the car simulator into the detector byte.
module uart_link #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] data_rec,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       tx_busy
);

    // Clocks per bit; must be at least 4 so the half-bit sample point is meaningful.
    localparam int DIV      = CLK_FREQ / BAUD;
    // One counter width serves both bit timing and the inter-frame gap.
    localparam int CNT_SPAN = (GAP_BITS > 1) ? GAP_BITS * DIV : DIV;
    localparam int CNT_W    = $clog2(CNT_SPAN);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS * DIV - 1 : 0);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_GAP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // ---------------------------------------------------------------------
    // Transmit side
    // ---------------------------------------------------------------------
    tx_state_t        tx_state;
    tx_state_t        tx_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;
    logic             tx_load;
    logic             tx_shift_en;
    logic             tx_bit;
    logic             tx_restart;

    // TX next-state and line level: the command byte is only captured at frame start.
    always_comb begin
        tx_next     = tx_state;
        tx_load     = 1'b0;
        tx_shift_en = 1'b0;
        tx_bit      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_load = 1'b1;
                tx_next = TX_START;
            end
            TX_START: begin
                tx_bit = 1'b0;
                if (tx_cnt == BIT_LAST) begin
                    tx_next = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_bit = tx_shift[0];
                if (tx_cnt == BIT_LAST) begin
                    tx_shift_en = 1'b1;
                    if (tx_idx == 3'd7) begin
                        tx_next = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    if (GAP_BITS == 0) begin
                        tx_load = 1'b1;
                        tx_next = TX_START;
                    end else begin
                        tx_next = TX_GAP;
                    end
                end
            end
            TX_GAP: begin
                if (tx_cnt == GAP_LAST) begin
                    tx_load = 1'b1;
                    tx_next = TX_START;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // The bit-time counter restarts on every state change and on every data bit boundary.
    assign tx_restart = (tx_next != tx_state) || tx_shift_en;

    // TX state, counters, shift register and the registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_restart ? '0 : tx_cnt + 1'b1;
            if (tx_load) begin
                tx_shift <= data_in;
                tx_idx   <= '0;
            end else if (tx_shift_en) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_idx   <= (tx_idx == 3'd7) ? 3'd0 : tx_idx + 3'd1;
            end
            txd     <= tx_bit;
            tx_busy <= (tx_state == TX_START) || (tx_state == TX_DATA) ||
                       (tx_state == TX_STOP);
        end
    end

    // ---------------------------------------------------------------------
    // Receive side
    // ---------------------------------------------------------------------
    logic             sync_p0;
    logic             rs;
    rx_state_t        rx_state;
    rx_state_t        rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_take;
    logic             rx_done;
    logic             rx_bad;
    logic             rx_restart;
    logic             rx_hold;

    // Two-flop synchronizer for the asynchronous serial input; idles high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= 1'b1;
            rs      <= 1'b1;
        end else begin
            sync_p0 <= rxd;
            rs      <= sync_p0;
        end
    end

    // RX next-state: start bit verified at mid-bit, data and stop sampled one bit-time apart.
    always_comb begin
        rx_next = rx_state;
        rx_take = 1'b0;
        rx_done = 1'b0;
        rx_bad  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rs) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_next = rs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_take = 1'b1;
                    if (rx_idx == 3'd7) begin
                        rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    if (rs) begin
                        rx_done = 1'b1;
                        rx_next = RX_IDLE;
                    end else begin
                        rx_bad  = 1'b1;
                        rx_next = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low line must return high before a new start bit counts.
                if (rs) begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Counter is parked at zero while waiting on the line so it can never wrap.
    assign rx_hold    = (rx_state == RX_IDLE) || (rx_state == RX_WAIT_HIGH);
    assign rx_restart = (rx_next != rx_state) || rx_take || rx_hold;

    // RX state, counters, shift register, received byte and status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            data_rec  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= rx_restart ? '0 : rx_cnt + 1'b1;
            if (rx_state == RX_IDLE) begin
                rx_idx <= '0;
            end else if (rx_take) begin
                rx_idx <= (rx_idx == 3'd7) ? 3'd0 : rx_idx + 3'd1;
            end
            if (rx_take) begin
                rx_shift <= {rs, rx_shift[7:1]};
            end
            if (rx_done) begin
                data_rec <= rx_shift;
            end
            rx_valid  <= rx_done;
            frame_err <= rx_bad;
        end
    end

endmodule
